// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_DASH;
        case (nib)
            4'd0: s = 7'h40;
            4'd1: s = 7'h79;
            4'd2: s = 7'h24;
            4'd3: s = 7'h30;
            4'd4: s = 7'h19;
            4'd5: s = 7'h12;
            4'd6: s = 7'h02;
            4'd7: s = 7'h78;
            4'd8: s = 7'h00;
            4'd9: s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_tick.sv
// Free-running prescaler: one-clock tick every DIV clocks.
module scan_tick_gen
    import seg7_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int CW = clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with a double-buffered value
// that only swaps in on a scan-frame boundary.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000,
    parameter int N_DIG   = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [4*N_DIG-1:0] value_in,
    input  logic               load,
    input  logic               lz_blank,
    output logic [6:0]         seg,
    output logic [N_DIG-1:0]   an,
    output logic               frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int IW  = (N_DIG > 1) ? clog2(N_DIG) : 1;

    logic               tick;
    logic [IW-1:0]      dig_idx;
    logic [4*N_DIG-1:0] shadow;
    logic [4*N_DIG-1:0] disp;
    logic               pending;

    logic               last;
    logic               wrap;
    logic [3:0]         nib;
    logic               blank;
    logic [6:0]         seg_nxt;
    logic [N_DIG-1:0]   an_nxt;

    scan_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .clr  (clr),
        .tick (tick)
    );

    // The digit latched on a tick is the one dig_idx points at before it advances.
    always_comb begin
        last    = (dig_idx == IW'(N_DIG - 1));
        wrap    = tick && last;
        nib     = disp[{dig_idx, 2'b00} +: 4];
        blank   = lz_blank && (dig_idx != '0)
                  && ((disp >> {dig_idx, 2'b00}) == '0);
        seg_nxt = blank ? SEG_OFF : bcd_to_seg(nib);
        an_nxt  = ~(N_DIG'(1) << dig_idx);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dig_idx    <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            seg        <= SEG_OFF;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (wrap && pending) begin
                disp <= shadow;
            end
            // A load on the boundary keeps pending so it shows next frame.
            if (load) begin
                shadow  <= value_in;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
            if (tick) begin
                seg     <= seg_nxt;
                an      <= an_nxt;
                dig_idx <= last ? '0 : dig_idx + 1'b1;
            end
        end
    end

endmodule
